// File: rtl/audio_frame_sequencer.sv
// Autonomous frame loop around an audio processor: load a frame from the source store,
// start the processor, wait for done, then drain the non-overlapped words to the sink.
module audio_frame_sequencer #(
  parameter int BUS_W   = 512,
  parameter int WORDS   = 64,
  parameter int IDX_W   = $clog2(WORDS),
  parameter int ADDR_W  = 18,
  parameter int FRAME_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic               abort,
  input  logic [FRAME_W-1:0] num_frames,
  input  logic [IDX_W:0]     hop,
  output logic [ADDR_W-1:0]  src_rd_idx,
  input  logic [BUS_W-1:0]   src_data,
  output logic               proc_wr_en,
  output logic [IDX_W-1:0]   proc_in_idx,
  output logic [BUS_W-1:0]   proc_data_in,
  output logic               proc_start,
  input  logic               proc_done,
  output logic [IDX_W-1:0]   proc_out_idx,
  input  logic [BUS_W-1:0]   proc_data_out,
  output logic               dst_wr_en,
  output logic [ADDR_W-1:0]  dst_wr_idx,
  output logic [BUS_W-1:0]   dst_data,
  output logic               busy,
  output logic               run_done,
  output logic [FRAME_W-1:0] frames_done,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_DRAIN = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t             r_state;
  logic [IDX_W:0]     r_hop;
  logic [FRAME_W-1:0] r_n;
  logic [FRAME_W-1:0] r_f;
  logic [IDX_W-1:0]   r_w;
  logic [ADDR_W-1:0]  r_base;
  logic               r_done_q;
  logic [FRAME_W-1:0] r_frames_done;

  logic [IDX_W:0]     w_hop_eff;
  logic [ADDR_W-1:0]  w_addr;
  logic               w_done_edge;
  logic               w_last_load;
  logic               w_last_drain;

  // A hop of zero or beyond the frame length degenerates to back-to-back frames.
  assign w_hop_eff    = (hop == '0 || hop > (IDX_W+1)'(WORDS)) ? (IDX_W+1)'(WORDS) : hop;
  assign w_addr       = r_base + ADDR_W'(r_w);
  assign w_done_edge  = proc_done & ~r_done_q;
  assign w_last_load  = (r_w == IDX_W'(WORDS - 1));
  assign w_last_drain = ({1'b0, r_w} == r_hop - (IDX_W+1)'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_hop         <= '0;
      r_n           <= '0;
      r_f           <= '0;
      r_w           <= '0;
      r_base        <= '0;
      r_done_q      <= 1'b0;
      r_frames_done <= '0;
    end else begin
      r_done_q <= proc_done;
      if (abort && r_state != S_IDLE) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (go) begin
              r_n   <= num_frames;
              r_hop <= w_hop_eff;
              if (num_frames == '0) begin
                r_state <= S_FIN;
              end else begin
                r_f           <= '0;
                r_w           <= '0;
                r_base        <= '0;
                r_frames_done <= '0;
                r_state       <= S_LOAD;
              end
            end
          end
          S_LOAD: begin
            if (w_last_load) begin
              r_w     <= '0;
              r_state <= S_START;
            end else begin
              r_w <= r_w + IDX_W'(1);
            end
          end
          S_START: r_state <= S_WAIT;
          S_WAIT: begin
            if (w_done_edge) r_state <= S_DRAIN;
          end
          S_DRAIN: begin
            if (w_last_drain) begin
              r_w           <= '0;
              r_frames_done <= r_frames_done + FRAME_W'(1);
              r_base        <= r_base + ADDR_W'(r_hop);
              if (r_f + FRAME_W'(1) == r_n) begin
                r_state <= S_FIN;
              end else begin
                r_f     <= r_f + FRAME_W'(1);
                r_state <= S_LOAD;
              end
            end else begin
              r_w <= r_w + IDX_W'(1);
            end
          end
          S_FIN:   r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Strobes and indices decode registered state/counters; indices read 0 outside their phase.
  assign busy         = (r_state != S_IDLE);
  assign run_done     = (r_state == S_FIN);
  assign proc_wr_en   = (r_state == S_LOAD);
  assign proc_start   = (r_state == S_START);
  assign dst_wr_en    = (r_state == S_DRAIN);
  assign proc_in_idx  = proc_wr_en ? r_w : '0;
  assign src_rd_idx   = proc_wr_en ? w_addr : '0;
  assign proc_out_idx = dst_wr_en ? r_w : '0;
  assign dst_wr_idx   = dst_wr_en ? w_addr : '0;
  assign proc_data_in = src_data;
  assign dst_data     = proc_data_out;
  assign frames_done  = r_frames_done;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_audio_frame_sequencer.sv
// Bench for audio_frame_sequencer: identity-copy processor model, source store and a
// scoreboard of expected load/drain transactions built from frame/hop arithmetic.
module tb_audio_frame_sequencer;
  localparam int BUS_W   = 512;
  localparam int WORDS   = 64;
  localparam int IDX_W   = 6;
  localparam int ADDR_W  = 18;
  localparam int FRAME_W = 16;
  localparam int DLY     = 20;
  localparam int P_FIX   = WORDS + 1 + DLY;
  localparam int LD_W    = IDX_W + ADDR_W;
  localparam int DS_W    = IDX_W + ADDR_W + BUS_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic               go, abort;
  logic [FRAME_W-1:0] num_frames;
  logic [IDX_W:0]     hop;
  logic [ADDR_W-1:0]  src_rd_idx, dst_wr_idx;
  logic [BUS_W-1:0]   src_data, proc_data_in, proc_data_out, dst_data;
  logic               proc_wr_en, proc_start, proc_done, dst_wr_en, busy, run_done;
  logic [IDX_W-1:0]   proc_in_idx, proc_out_idx;
  logic [FRAME_W-1:0] frames_done;
  logic [2:0]         dbg_state;

  logic [6:0]         src_rd_idx_7, dst_wr_idx_7;
  logic [BUS_W-1:0]   src_data_7, proc_data_in_7, dst_data_7;
  logic               proc_wr_en_7, proc_start_7, dst_wr_en_7, busy_7, run_done_7;
  logic [IDX_W-1:0]   proc_in_idx_7, proc_out_idx_7;
  logic [FRAME_W-1:0] frames_done_7;
  logic [2:0]         dbg_state_7;

  audio_frame_sequencer u_dut (
    .clk(clk), .rst(rst), .go(go), .abort(abort), .num_frames(num_frames), .hop(hop),
    .src_rd_idx(src_rd_idx), .src_data(src_data), .proc_wr_en(proc_wr_en),
    .proc_in_idx(proc_in_idx), .proc_data_in(proc_data_in), .proc_start(proc_start),
    .proc_done(proc_done), .proc_out_idx(proc_out_idx), .proc_data_out(proc_data_out),
    .dst_wr_en(dst_wr_en), .dst_wr_idx(dst_wr_idx), .dst_data(dst_data), .busy(busy),
    .run_done(run_done), .frames_done(frames_done), .dbg_state(dbg_state)
  );

  // Narrow-address twin running in lockstep; only its addresses are checked (wrap at 128).
  audio_frame_sequencer #(.ADDR_W(7)) u_dut7 (
    .clk(clk), .rst(rst), .go(go), .abort(abort), .num_frames(num_frames), .hop(hop),
    .src_rd_idx(src_rd_idx_7), .src_data(src_data_7), .proc_wr_en(proc_wr_en_7),
    .proc_in_idx(proc_in_idx_7), .proc_data_in(proc_data_in_7), .proc_start(proc_start_7),
    .proc_done(proc_done), .proc_out_idx(proc_out_idx_7), .proc_data_out(proc_data_out),
    .dst_wr_en(dst_wr_en_7), .dst_wr_idx(dst_wr_idx_7), .dst_data(dst_data_7), .busy(busy_7),
    .run_done(run_done_7), .frames_done(frames_done_7), .dbg_state(dbg_state_7)
  );

  // source store and processor model
  logic [BUS_W-1:0] src_mem [0:255];
  logic [BUS_W-1:0] in_buf  [0:WORDS-1];
  logic [BUS_W-1:0] out_buf [0:WORDS-1];
  logic r_pdone = 1'b0;
  int   p_cnt = 0;
  logic hold_mode, man_done;

  assign src_data      = src_mem[src_rd_idx[7:0]];
  assign src_data_7    = src_mem[{1'b0, src_rd_idx_7}];
  assign proc_done     = hold_mode ? man_done : r_pdone;
  assign proc_data_out = out_buf[proc_out_idx];

  always @(posedge clk) begin
    if (proc_wr_en) in_buf[proc_in_idx] <= proc_data_in;
    if (proc_start) begin
      r_pdone <= 1'b0;
      p_cnt   <= DLY - 1;
    end else if (p_cnt != 0) begin
      p_cnt <= p_cnt - 1;
      if (p_cnt == 1) begin
        r_pdone <= 1'b1;
        for (int i = 0; i < WORDS; i++) out_buf[i] <= in_buf[i];
      end
    end
  end

  // scoreboard
  logic [LD_W-1:0] exp_ld_q[$];
  logic [DS_W-1:0] exp_dst_q[$];
  int start_cyc[$];
  int checks = 0, failures = 0;
  int ld_seen = 0, dst_seen = 0, rd_cnt = 0, rd_cyc = 0, go_cyc = 0;

  task automatic check_val(input string tag, input logic [BUS_W-1:0] got,
                           input logic [BUS_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [LD_W-1:0] el;
    logic [DS_W-1:0] ed;
    if (!rst) begin
      if (proc_wr_en) begin
        ld_seen++;
        if (exp_ld_q.size() == 0) check_val("ld_extra", 1, 0);
        else begin
          el = exp_ld_q.pop_front();
          check_val("src_rd_idx", src_rd_idx, el[ADDR_W-1:0]);
          check_val("proc_in_idx", proc_in_idx, el[LD_W-1:ADDR_W]);
          check_val("proc_data_in", proc_data_in, src_mem[el[7:0]]);
          check_val("wr_en_a7", proc_wr_en_7, 1);
          check_val("src_rd_idx_a7", src_rd_idx_7, el[6:0]);
        end
      end
      if (dst_wr_en) begin
        dst_seen++;
        if (exp_dst_q.size() == 0) check_val("dst_extra", 1, 0);
        else begin
          ed = exp_dst_q.pop_front();
          check_val("dst_wr_idx", dst_wr_idx, ed[BUS_W+ADDR_W-1:BUS_W]);
          check_val("proc_out_idx", proc_out_idx, ed[DS_W-1:BUS_W+ADDR_W]);
          check_val("dst_data", dst_data, ed[BUS_W-1:0]);
          check_val("dst_en_a7", dst_wr_en_7, 1);
          check_val("dst_wr_idx_a7", dst_wr_idx_7, ed[BUS_W+6:BUS_W]);
        end
      end
      if (proc_start) start_cyc.push_back(cyc);
      if (run_done) begin
        rd_cnt++;
        rd_cyc = cyc;
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int eff_hop(input int h);
    return (h == 0 || h > WORDS) ? WORDS : h;
  endfunction

  task automatic plan_run(input int n, input int hop_in);
    int h, a;
    h = eff_hop(hop_in);
    exp_ld_q.delete();
    exp_dst_q.delete();
    start_cyc.delete();
    ld_seen  = 0;
    dst_seen = 0;
    for (int k = 0; k < n; k++) begin
      for (int w = 0; w < WORDS; w++) begin
        a = k * h + w;
        exp_ld_q.push_back({IDX_W'(w), ADDR_W'(a)});
      end
      for (int j = 0; j < h; j++) begin
        a = k * h + j;
        exp_dst_q.push_back({IDX_W'(j), ADDR_W'(a), src_mem[a]});
      end
    end
  endtask

  task automatic do_go(input int n, input int hop_in);
    go         = 1'b1;
    num_frames = FRAME_W'(n);
    hop        = (IDX_W+1)'(hop_in);
    go_cyc     = cyc;
    tick(1);
    go         = 1'b0;
    num_frames = FRAME_W'($urandom);
    hop        = (IDX_W+1)'($urandom);
  endtask

  task automatic wait_run(input int r0, input int budget);
    int i = 0;
    while (rd_cnt == r0 && i < budget) begin
      tick(1);
      i++;
    end
    if (rd_cnt == r0) check_val("run_timeout", 0, 1);
  endtask

  task automatic run_frames(input int n, input int hop_in);
    int h, r0;
    h = eff_hop(hop_in);
    plan_run(n, hop_in);
    r0 = rd_cnt;
    do_go(n, hop_in);
    wait_run(r0, n * 200 + 200);
    tick(3);
    check_val("run_done_pulses", rd_cnt - r0, 1);
    check_val("run_len", rd_cyc, go_cyc + 1 + n * (P_FIX + h));
    check_val("frames_done", frames_done, n);
    check_val("ld_count", ld_seen, n * WORDS);
    check_val("dst_count", dst_seen, n * h);
    check_val("ld_q_left", exp_ld_q.size(), 0);
    check_val("dst_q_left", exp_dst_q.size(), 0);
    check_val("busy_after", busy, 0);
    if (start_cyc.size() > 0) check_val("first_start", start_cyc[0], go_cyc + 1 + WORDS);
    else check_val("no_start", 0, 1);
    for (int k = 1; k < start_cyc.size(); k++)
      check_val("frame_period", start_cyc[k] - start_cyc[k-1], P_FIX + h);
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_run_done"}, run_done, 0);
    check_val({tag, "_strobes"}, {proc_wr_en, proc_start, dst_wr_en}, 0);
    check_val({tag, "_idx"}, {src_rd_idx, dst_wr_idx, proc_in_idx, proc_out_idx}, 0);
  endtask

  initial begin
    int r0, c, i;
    for (int k = 0; k < 256; k++)
      for (int j = 0; j < BUS_W / 32; j++) src_mem[k][j*32 +: 32] = $urandom;
    rst = 1'b1; go = 1'b0; abort = 1'b0; num_frames = '0; hop = '0;
    hold_mode = 1'b0; man_done = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(10);
    check_idle("reset");
    check_val("reset_frames_done", frames_done, 0);

    run_frames(3, 64);
    run_frames(4, 32);
    run_frames(2, 0);
    repeat (3) run_frames($urandom_range(1, 3), $urandom_range(0, 90));

    // done held high across START must not count as an edge
    plan_run(1, 64);
    hold_mode = 1'b1;
    man_done  = 1'b1;
    r0 = rd_cnt;
    do_go(1, 64);
    i = 0;
    while (start_cyc.size() == 0 && i < 200) begin tick(1); i++; end
    tick(30);
    check_val("hold_no_drain", dst_seen, 0);
    check_val("hold_busy", busy, 1);
    man_done = 1'b0;
    tick(3);
    check_val("hold_low_no_drain", dst_seen, 0);
    man_done = 1'b1;
    c = cyc;
    wait_run(r0, 200);
    check_val("hold_fin_cycle", rd_cyc, c + 1 + WORDS);
    check_val("hold_frames_done", frames_done, 1);
    check_val("hold_dst_q_left", exp_dst_q.size(), 0);
    hold_mode = 1'b0;
    tick(3);

    // abort in WAIT of the second frame; a stray go mid-run is ignored
    plan_run(5, 64);
    r0 = rd_cnt;
    do_go(5, 64);
    tick(10);
    go = 1'b1; num_frames = 7; hop = 16;
    tick(1);
    go = 1'b0;
    i = 0;
    while (start_cyc.size() < 2 && i < 400) begin tick(1); i++; end
    tick(5);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check_idle("abort");
    check_val("abort_frames_done", frames_done, 1);
    tick(5);
    check_val("abort_no_run_done", rd_cnt, r0);
    check_val("abort_ld_count", ld_seen, 2 * WORDS);
    check_val("abort_dst_count", dst_seen, WORDS);
    plan_run(0, 64);

    // zero frames: FIN right after go, nothing else
    r0 = rd_cnt;
    do_go(0, 64);
    check_val("nf0_run_done", run_done, 1);
    check_val("nf0_busy", busy, 1);
    check_val("nf0_strobes", {proc_wr_en, proc_start, dst_wr_en}, 0);
    tick(1);
    check_idle("nf0_after");
    check_val("nf0_pulses", rd_cnt - r0, 1);
    check_val("nf0_cycle", rd_cyc, go_cyc + 1);
    check_val("nf0_no_loads", ld_seen, 0);

    // reset in the middle of a run
    plan_run(2, 32);
    do_go(2, 32);
    tick(130);
    check_val("midrst_frames_before", frames_done, 1);
    rst = 1'b1;
    tick(1);
    check_idle("midrst");
    check_val("midrst_frames_done", frames_done, 0);
    rst = 1'b0;
    plan_run(0, 64);
    tick(5);
    check_idle("midrst_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog got=%0d exp=0", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/audio_frame_sequencer.md
# audio_frame_sequencer

- Hardware replacement for the bench-driven frame loop around `AudioProcessor`: `load 64 words -> start -> wait done -> read 64 words`, repeated.
- Runs N frames autonomously:
  - reads 512-bit words from a source store and writes them into the processor input buffer;
  - pulses start and waits for the rising edge of done;
  - drains the processor output buffer into a sink store.
- Generalised over bus width, frame length and index width.
- Adds a runtime hop size for overlapped frames, plus abort.

## Interface
Parameters:
- `BUS_W`, 512, data word width.
- `WORDS`, 64, words per frame; power of two, ≥2.
- `IDX_W`, `$clog2(WORDS)`, processor buffer index width.
- `ADDR_W`, 18, source/sink word address width.
- `FRAME_W`, 16, frame count width.

Ports:
- `clk` in 1, single clock, rising edge.
- `rst` in 1, synchronous active-high reset.
- `go` in 1, start a run; sampled in IDLE only.
- `abort` in 1, terminate the run.
- `num_frames` in FRAME_W, frames per run; latched on go.
- `hop` in IDX_W+1, frame advance in words; latched on go. Values 0 or >WORDS are treated as WORDS.
- `src_rd_idx` out ADDR_W, source word address.
- `src_data` in BUS_W, source word; combinational read of `src_rd_idx`.
- `proc_wr_en` out 1, processor input write strobe.
- `proc_in_idx` out IDX_W, processor input index.
- `proc_data_in` out BUS_W, equal to `src_data` (combinational pass-through).
- `proc_start` out 1, one-cycle start pulse.
- `proc_done` in 1, processor done level.
- `proc_out_idx` out IDX_W, processor output index.
- `proc_data_out` in BUS_W, processor output word for `proc_out_idx`; combinational read.
- `dst_wr_en` out 1, sink write strobe.
- `dst_wr_idx` out ADDR_W, sink word address.
- `dst_data` out BUS_W, equal to `proc_data_out`.
- `busy` out 1, high in every state except IDLE.
- `run_done` out 1, one-cycle pulse when a run completes.
- `frames_done` out FRAME_W, count of frames fully drained in the current or last run.

## Operation
- Run-time registers:
  - `hop_r`: effective hop, latched on go.
  - `n_r`: frame count, latched on go.
  - `f`: frame counter.
  - `w`: word counter.
  - `base`: frame base address, equal to `f*hop_r` modulo 2^ADDR_W, kept as a running sum.
- State machine:
  - IDLE: on go with `num_frames`=0, go to FIN. On go with `num_frames`≠0, go to LOAD; `f`, `w`, `base` and `frames_done` clear to 0.
  - LOAD:
    - Drives `proc_wr_en`=1, `proc_in_idx`=`w`, `src_rd_idx`=`base+w`.
    - After `w`=WORDS-1, go to START with `w`=0.
  - START: `proc_start`=1 for exactly one cycle, then go to WAIT.
  - WAIT:
    - Waits for a `proc_done` rising edge. The edge is `proc_done & ~done_q`, where `done_q` is registered every cycle in every state.
    - A done level already high on entry is ignored.
    - No timeout.
  - DRAIN:
    - Drives `dst_wr_en`=1, `proc_out_idx`=`w`, `dst_wr_idx`=`base+w`, for `w`=0..`hop_r`-1.
    - Output words `hop_r`..WORDS-1 are discarded; they are the overlap owned by the next frame.
    - On the last word: `frames_done` increments and `base` += `hop_r`. If `f+1`=`n_r`, go to FIN; otherwise `f` increments and the next state is LOAD.
  - FIN: `run_done`=1 for one cycle, then IDLE.
- Addresses wrap modulo 2^ADDR_W with no error.
- go is ignored when not in IDLE. `num_frames` and `hop` are don't-care outside the go cycle.
- abort, any non-IDLE state: next state IDLE, all strobes low, no `run_done`, `frames_done` holds. abort has priority over every transition, including go in the same cycle.
- Processor settings (pitch, equalizer, overdrive, tremolo) are not touched by this block.

## Timing
- All strobes and indices are Moore outputs of registered state and counters; data buses are combinational pass-throughs.
- Reset values: state IDLE, all strobes 0, all indices 0, `busy`=0, `run_done`=0, `frames_done`=0, `done_q`=0.
- Cycle after go: first LOAD cycle.
- Cycles per frame: WORDS + 1 (START) + wait + `hop_r`.
  - wait is the number of WAIT cycles up to and including the cycle where the edge is seen.
  - DRAIN starts the cycle after that edge.
- `num_frames`=0: `run_done` in the cycle after go, `busy` high for that one cycle only.
- `rst` mid-run has the same effect as reset from power-up. Any partially written frame is left in the stores.

## Test plan
- Reset then idle 10 cycles -> all outputs 0, `busy`=0.
- go with `num_frames`=3, `hop`=64, WORDS=64, model processor asserting done 20 cycles after start (done=1 identity copy):
  - `src_rd_idx` sequence is 0..191;
  - sink receives 192 words equal to the source;
  - each frame takes 64+1+20+64 cycles;
  - `run_done` pulses once; `frames_done`=3.
- `hop`=32, `num_frames`=4:
  - frame k reads source addresses 32k..32k+63;
  - sink writes only 32k..32k+31, each from output index 0..31;
  - `frames_done`=4.
- `proc_done` held high from before start and through START -> no DRAIN until done falls and rises again.
- abort in WAIT of frame 2 of 5 -> IDLE next cycle, `frames_done`=1, no `run_done`; a go during the run is ignored.
- `num_frames`=0 -> `run_done` in the cycle after go, zero strobes. `hop`=0 -> behaves as 64. `ADDR_W`=7 with 3 frames -> addresses wrap 127->0.
